// File: rtl/power_exp.sv
// power_exp: sequential unsigned exponentiation, o_data = i_data ** i_exp
// truncated to OUT_WIDTH bits, computed as i_exp repeated multiplies.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   reset_n  - asynchronous active-low reset
//   i_valid  - request valid (sampled only while o_ready=1)
//   o_ready  - block idle and able to accept a request
//   i_data   - unsigned base
//   i_exp    - unsigned exponent
//   o_valid  - result valid, held until i_ready=1
//   i_ready  - downstream accepts the result
//   o_data   - result, (i_data ** i_exp) mod 2**OUT_WIDTH
//   o_ovf    - true result did not fit in OUT_WIDTH bits
module power_exp #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OUT_WIDTH  = 64,
    parameter int unsigned EXP_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [EXP_WIDTH-1:0]  i_exp,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [OUT_WIDTH-1:0]  o_data,
    output logic                  o_ovf
);

    localparam int unsigned PROD_WIDTH = OUT_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   base_q,  base_d;
    logic [EXP_WIDTH-1:0]    cnt_q,   cnt_d;
    logic [OUT_WIDTH-1:0]    acc_q,   acc_d;
    logic                    ovf_q,   ovf_d;
    logic [PROD_WIDTH-1:0]   prod;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        // Full-width product so the bits above OUT_WIDTH reveal overflow.
        prod    = PROD_WIDTH'(acc_q) * PROD_WIDTH'(base_q);

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    base_d  = i_data;
                    cnt_d   = i_exp;
                    acc_d   = OUT_WIDTH'(1);
                    ovf_d   = 1'b0;
                    state_d = (i_exp == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                acc_d = prod[OUT_WIDTH-1:0];
                ovf_d = ovf_q | (|prod[PROD_WIDTH-1:OUT_WIDTH]);
                cnt_d = cnt_q - EXP_WIDTH'(1);
                if (cnt_q == EXP_WIDTH'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from state and registers only. reset_n gates o_ready
    // so the block never advertises readiness while held in reset.
    always_comb begin
        o_ready = (state_q == IDLE) && reset_n;
        o_valid = (state_q == DONE);
        o_data  = acc_q;
        o_ovf   = ovf_q;
    end

endmodule

// File: doc/power_exp.md
POWER_EXP -- requirements
Module: power_exp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the unsigned base operand width.
REQ-002 SHALL have parameter OUT_WIDTH, default 64, meaning the result width; OUT_WIDTH >= DATA_WIDTH.
REQ-003 SHALL have parameter EXP_WIDTH, default 4, meaning the exponent width, giving exponents 0..2^EXP_WIDTH-1.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 i_valid  input  1  request valid.
REQ-007 o_ready  output  1  block can accept a request.
REQ-008 i_data  input  DATA_WIDTH  unsigned base.
REQ-009 i_exp  input  EXP_WIDTH  unsigned exponent.
REQ-010 o_valid  output  1  result valid.
REQ-011 i_ready  input  1  downstream accepts the result.
REQ-012 o_data  output  OUT_WIDTH  result, (i_data^i_exp) mod 2^OUT_WIDTH.
REQ-013 o_ovf  output  1  the true result exceeded OUT_WIDTH bits.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-015 o_ready SHALL be 1 only in IDLE; o_valid SHALL be 1 only in DONE; both SHALL be registered or decoded from state only, with no combinational path from any input.
REQ-016 In IDLE, a request SHALL be accepted on the edge where i_valid=1 and o_ready=1: base<=i_data, cnt<=i_exp, acc<=1, ovf<=0.
REQ-017 At acceptance with i_exp=0, the FSM SHALL go directly to DONE with o_data=1 and o_ovf=0.
REQ-018 At acceptance with i_exp>0, the FSM SHALL go to CALC.
REQ-019 In CALC, each edge SHALL update acc <= low OUT_WIDTH bits of acc*base, using a full (OUT_WIDTH+DATA_WIDTH)-bit product.
REQ-020 In CALC, each edge SHALL set ovf <= ovf OR (upper DATA_WIDTH product bits != 0), and SHALL decrement cnt.
REQ-021 On the CALC edge where cnt=1, the FSM SHALL go to DONE; exactly i_exp multiplies SHALL occur.
REQ-022 Latency: for a request accepted at edge k with exponent E, o_valid SHALL rise after edge k+E for E>=1, and after edge k for E=0.
REQ-023 o_ovf SHALL be sticky for the operation and SHALL be cleared only on acceptance or reset.
REQ-024 In DONE, o_data and o_ovf SHALL hold stable until the edge where i_ready=1.
REQ-025 On the edge where o_valid=1 and i_ready=1, the FSM SHALL return to IDLE; o_ready SHALL be 1 in the following cycle.
REQ-026 There SHALL be no same-cycle accept-while-completing; maximum throughput is one op per E+2 cycles (E>=1).
REQ-027 i_valid in CALC or DONE SHALL be ignored; i_data and i_exp SHALL be sampled only at acceptance.
REQ-028 i_ready outside DONE SHALL have no effect.
REQ-029 All arithmetic SHALL be unsigned.
REQ-030 Base 0 with E>=1 SHALL yield 0; base 1 SHALL yield 1; neither SHALL set ovf.

Reset
REQ-031 reset_n=0 SHALL immediately, without waiting for clk, force state=IDLE, o_valid=0, o_data=0, o_ovf=0, cnt=0, base=0, and acc=0.
REQ-032 o_ready SHALL be 0 while reset_n=0 and SHALL be 1 in the first cycle after release.
REQ-033 Reset asserted in CALC or DONE SHALL abort the operation with no result delivered.
REQ-034 The first request after reset release SHALL compute correctly.

Verification
Benches drive inputs with non-blocking assignments on posedge clk.
REQ-035 i_data=2, i_exp=3, i_ready=1 -> o_data=8, o_ovf=0, o_valid high 3 cycles after acceptance for 1 cycle.
REQ-036 i_data=0xFFFFFFFF, i_exp=0 -> o_data=1, o_ovf=0, o_valid 1 cycle after acceptance.
REQ-037 i_data=0xFFFFFFFF, i_exp=3 -> o_data=0x00000002FFFFFFFF, o_ovf=1; i_exp=2 -> 0xFFFFFFFE00000001, o_ovf=0.
REQ-038 Backpressure: result 0x10 (2^4) held with i_ready=0 for 4 cycles while i_valid=1 and i_data=7 -> o_data stable, o_ready=0, 7 not accepted; after i_ready=1, next cycle o_ready=1.
REQ-039 reset_n pulsed low mid-CALC (i_data=3, i_exp=15) -> o_valid, o_data, and o_ovf are 0 asynchronously; then i_data=3, i_exp=2 -> o_data=9.
REQ-040 Back-to-back stream i_data=2..6, i_exp=2, i_ready=1 -> o_data 4, 9, 16, 25, 36 in order, none dropped or duplicated.
